// File: rtl/def_ss_pkg.sv
// Shared types and helpers for the def_ss stream arbiter slice.
package def_ss_pkg;

  localparam int NUM_SRC = 2;

  typedef enum logic [0:0] {
    SRC_0 = 1'b0,
    SRC_1 = 1'b1
  } src_id_t;

  // One extra pointer bit tells a full FIFO apart from an empty one.
  function automatic int fifo_ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/def_ss_fifo.sv
// Per-source synchronous FIFO; pushes while full and pops while empty are ignored.
module def_ss_fifo
  import def_ss_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DATA_WIDTH-1:0] head_o
);

  localparam int PW = fifo_ptr_width(FIFO_DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign head_o    = mem_q[rd_ptr_q[AW-1:0]];
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;

  // Storage and pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        wr_ptr_q                <= wr_ptr_q + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/def_ss_arb.sv
// Merges the two def_ss instance streams into one source-tagged valid/ready
// output with round-robin arbitration and saturating forwarded-word counters.
module def_ss_arb
  import def_ss_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_data_0,
  input  logic                  i_vld_0,
  output logic                  o_rdy_0,
  input  logic [DATA_WIDTH-1:0] i_data_1,
  input  logic                  i_vld_1,
  output logic                  o_rdy_1,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_src,
  output logic                  o_vld,
  input  logic                  i_rdy,
  output logic [CNT_WIDTH-1:0]  o_cnt_0,
  output logic [CNT_WIDTH-1:0]  o_cnt_1
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [NUM_SRC-1:0]    full_s, empty_s, push_s, pop_s;
  logic [DATA_WIDTH-1:0] head_0_s, head_1_s;
  logic                  load_s, any_s, xfer_s;
  src_id_t               grant_s;

  logic                  vld_q, vld_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  src_id_t               src_q, src_d;
  src_id_t               last_q, last_d;
  logic [CNT_WIDTH-1:0]  cnt_0_q, cnt_0_d, cnt_1_q, cnt_1_d;

  assign push_s[0] = i_vld_0 & ~full_s[0];
  assign push_s[1] = i_vld_1 & ~full_s[1];

  def_ss_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_0 (
    .clk(clk), .rst(rst), .push_i(push_s[0]), .data_i(i_data_0), .pop_i(pop_s[0]),
    .full_o(full_s[0]), .empty_o(empty_s[0]), .head_o(head_0_s)
  );

  def_ss_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_1 (
    .clk(clk), .rst(rst), .push_i(push_s[1]), .data_i(i_data_1), .pop_i(pop_s[1]),
    .full_o(full_s[1]), .empty_o(empty_s[1]), .head_o(head_1_s)
  );

  assign load_s = ~vld_q | i_rdy;
  assign any_s  = (empty_s != 2'b11);
  assign xfer_s = vld_q & i_rdy;

  // Round-robin grant: a lone non-empty FIFO wins, otherwise the one not served last.
  always_comb begin
    grant_s = SRC_0;
    case (empty_s)
      2'b00:   grant_s = (last_q == SRC_0) ? SRC_1 : SRC_0;
      2'b01:   grant_s = SRC_1;
      2'b10:   grant_s = SRC_0;
      default: grant_s = SRC_0;
    endcase
  end

  // Output register, pop strobes and counters next state.
  always_comb begin
    vld_d   = vld_q;
    data_d  = data_q;
    src_d   = src_q;
    last_d  = last_q;
    pop_s   = 2'b00;
    cnt_0_d = cnt_0_q;
    cnt_1_d = cnt_1_q;
    if (load_s && any_s) begin
      vld_d  = 1'b1;
      data_d = (grant_s == SRC_1) ? head_1_s : head_0_s;
      src_d  = grant_s;
      last_d = grant_s;
      pop_s  = (grant_s == SRC_1) ? 2'b10 : 2'b01;
    end else if (load_s) begin
      vld_d = 1'b0;
    end else begin
      vld_d = vld_q;
    end
    if (xfer_s && (src_q == SRC_0) && (cnt_0_q != '1)) begin
      cnt_0_d = cnt_0_q + CNT_ONE;
    end else if (xfer_s && (src_q == SRC_1) && (cnt_1_q != '1)) begin
      cnt_1_d = cnt_1_q + CNT_ONE;
    end else begin
      cnt_0_d = cnt_0_q;
    end
  end

  // State registers; last starts at source 1 so source 0 wins first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= 1'b0;
      data_q  <= '0;
      src_q   <= SRC_0;
      last_q  <= SRC_1;
      cnt_0_q <= '0;
      cnt_1_q <= '0;
    end else begin
      vld_q   <= vld_d;
      data_q  <= data_d;
      src_q   <= src_d;
      last_q  <= last_d;
      cnt_0_q <= cnt_0_d;
      cnt_1_q <= cnt_1_d;
    end
  end

  assign o_rdy_0 = ~full_s[0];
  assign o_rdy_1 = ~full_s[1];
  assign o_vld   = vld_q;
  assign o_data  = data_q;
  assign o_src   = src_q;
  assign o_cnt_0 = cnt_0_q;
  assign o_cnt_1 = cnt_1_q;

endmodule

// File: tb/tb_def_ss_arb.sv
// Self-checking bench for def_ss_arb: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_def_ss_arb;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int CMAX  = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] i_data_0, i_data_1, o_data;
  logic          i_vld_0, i_vld_1, o_rdy_0, o_rdy_1, o_src, o_vld, i_rdy;
  logic [CW-1:0] o_cnt_0, o_cnt_1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  def_ss_arb #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .i_data_0(i_data_0), .i_vld_0(i_vld_0), .o_rdy_0(o_rdy_0),
    .i_data_1(i_data_1), .i_vld_1(i_vld_1), .o_rdy_1(o_rdy_1),
    .o_data(o_data), .o_src(o_src), .o_vld(o_vld), .i_rdy(i_rdy),
    .o_cnt_0(o_cnt_0), .o_cnt_1(o_cnt_1)
  );

  // Reference model: one queue per source, the output slot, and the last-served source.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic          m_vld, m_src, m_last;
  logic [DW-1:0] m_data;
  int            m_cnt0, m_cnt1;

  task automatic model_tick();
    bit a0, a1;
    if (rst) begin
      q0.delete(); q1.delete();
      m_vld = 1'b0; m_data = '0; m_src = 1'b0; m_last = 1'b1;
      m_cnt0 = 0; m_cnt1 = 0;
      return;
    end
    a0 = i_vld_0 && (q0.size() < DEPTH);
    a1 = i_vld_1 && (q1.size() < DEPTH);
    if (m_vld && i_rdy) begin
      if (m_src == 1'b0) m_cnt0 = (m_cnt0 < CMAX) ? m_cnt0 + 1 : CMAX;
      else               m_cnt1 = (m_cnt1 < CMAX) ? m_cnt1 + 1 : CMAX;
    end
    if (!m_vld || i_rdy) begin
      if (q0.size() > 0 && (q1.size() == 0 || m_last == 1'b1)) begin
        m_data = q0.pop_front(); m_src = 1'b0; m_last = 1'b0; m_vld = 1'b1;
      end else if (q1.size() > 0) begin
        m_data = q1.pop_front(); m_src = 1'b1; m_last = 1'b1; m_vld = 1'b1;
      end else begin
        m_vld = 1'b0;
      end
    end
    if (a0) q0.push_back(i_data_0);
    if (a1) q1.push_back(i_data_1);
  endtask

  function automatic logic [19:0] dut_vec();
    return {o_vld, o_data, o_src, o_rdy_0, o_rdy_1, o_cnt_0, o_cnt_1};
  endfunction

  function automatic logic [19:0] model_vec();
    return {m_vld, m_data, m_src, (q0.size() < DEPTH), (q1.size() < DEPTH), CW'(m_cnt0), CW'(m_cnt1)};
  endfunction

  // Apply one cycle of inputs just after an edge, advance the model, sample 1 ns after the next edge.
  task automatic cycle(input bit r, input bit v0, input logic [DW-1:0] d0,
                       input bit v1, input logic [DW-1:0] d1, input bit rd);
    rst = r; i_vld_0 = v0; i_data_0 = d0; i_vld_1 = v1; i_data_1 = d1; i_rdy = rd;
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    n_total++;
    if ({o_vld, o_data, o_src, o_cnt_0, o_cnt_1, o_rdy_0, o_rdy_1} !== {1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1})
      $display("FAIL reset_values got=%h want=%h", {o_vld, o_data, o_src, o_cnt_0, o_cnt_1, o_rdy_0, o_rdy_1},
               {1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1});
    else n_pass++;
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    n_total++;
    if (o_vld !== 1'b0) $display("FAIL reset_idle_vld got=%b want=0", o_vld); else n_pass++;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'(8'h50 + i), 1'b1, 8'(8'h60 + i), 1'b0);
    n_total++;
    if (o_vld !== 1'b1) $display("FAIL midburst_loaded got=%b want=1", o_vld); else n_pass++;
    cycle(1'b1, 1'b1, 8'h5F, 1'b1, 8'h6F, 1'b1);
    n_total++;
    if ({o_vld, o_data, o_rdy_0, o_rdy_1} !== {1'b0, 8'h00, 1'b1, 1'b1})
      $display("FAIL midburst_reset got=%h want=%h", {o_vld, o_data, o_rdy_0, o_rdy_1}, {1'b0, 8'h00, 1'b1, 1'b1});
    else n_pass++;
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    n_total++;
    if (o_vld !== 1'b0) $display("FAIL midburst_fifos_empty got=%b want=0", o_vld); else n_pass++;
  endtask

  task automatic test_single();
    logic [DW-1:0] st [5];
    logic [DW-1:0] ed [5];
    bit            sv [5];
    bit            ev [5];
    st = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00};
    sv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    ed = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, sv[i], st[i], 1'b0, 8'h00, 1'b1);
      n_total++;
      if (ev[i] && ({o_vld, o_data, o_src} !== {1'b1, ed[i], 1'b0}))
        $display("FAIL single_word%0d got=%h want=%h", i, {o_vld, o_data, o_src}, {1'b1, ed[i], 1'b0});
      else if (!ev[i] && o_vld !== 1'b0)
        $display("FAIL single_idle%0d got vld=%b want 0", i, o_vld);
      else n_pass++;
    end
    n_total++;
    if ({o_cnt_0, o_cnt_1} !== {4'd3, 4'd0}) $display("FAIL single_count got=%h want=30", {o_cnt_0, o_cnt_1});
    else n_pass++;
  endtask

  task automatic test_contention();
    logic [8:0] obs[$];
    logic [8:0] exp_w;
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (o_vld) obs.push_back({o_src, o_data});
      if (i < 4) cycle(1'b0, 1'b1, 8'(8'hA0 + i), 1'b1, 8'(8'hB0 + i), 1'b1);
      else       cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    end
    n_total++;
    if (obs.size() != 8) $display("FAIL contention_words got=%0d want=8", obs.size()); else n_pass++;
    for (int i = 0; i < 8 && i < obs.size(); i++) begin
      exp_w = (i % 2 == 0) ? {1'b0, 8'(8'hA0 + i / 2)} : {1'b1, 8'(8'hB0 + i / 2)};
      n_total++;
      if (obs[i] !== exp_w) $display("FAIL contention_order%0d got=%h want=%h", i, obs[i], exp_w); else n_pass++;
    end
    n_total++;
    if ({o_cnt_0, o_cnt_1} !== {4'd4, 4'd4}) $display("FAIL contention_count got=%h want=44", {o_cnt_0, o_cnt_1});
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] obs[$];
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 8'(8'hC0 + i), 1'b0);
      n_total++;
      if (o_rdy_1 !== ((i < 4) ? 1'b1 : 1'b0))
        $display("FAIL bp_rdy%0d got=%b want=%b", i, o_rdy_1, (i < 4) ? 1'b1 : 1'b0);
      else if (i >= 1 && {o_vld, o_data, o_src} !== {1'b1, 8'hC0, 1'b1})
        $display("FAIL bp_hold%0d got=%h want=%h", i, {o_vld, o_data, o_src}, {1'b1, 8'hC0, 1'b1});
      else n_pass++;
    end
    for (int i = 0; i < 12; i++) begin
      if (o_vld) obs.push_back(o_data);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    end
    n_total++;
    if (obs.size() != 5) $display("FAIL bp_words got=%0d want=5", obs.size()); else n_pass++;
    for (int i = 0; i < 5 && i < obs.size(); i++) begin
      n_total++;
      if (obs[i] !== 8'(8'hC0 + i)) $display("FAIL bp_order%0d got=%h want=%h", i, obs[i], 8'(8'hC0 + i));
      else n_pass++;
    end
  endtask

  task automatic test_full_pushpop();
    logic [DW-1:0] obs[$];
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'(8'hD0 + i), 1'b0, 8'h00, 1'b0);
    n_total++;
    if (o_rdy_0 !== 1'b0) $display("FAIL full_rdy got=%b want=0", o_rdy_0); else n_pass++;
    obs.push_back(o_data);
    cycle(1'b0, 1'b1, 8'hEE, 1'b0, 8'h00, 1'b1);
    n_total++;
    if ({o_rdy_0, o_vld, o_data} !== {1'b1, 1'b1, 8'hD1})
      $display("FAIL full_pushpop got=%h want=%h", {o_rdy_0, o_vld, o_data}, {1'b1, 1'b1, 8'hD1});
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      if (o_vld) obs.push_back(o_data);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    end
    n_total++;
    if (obs.size() != 5) $display("FAIL full_words got=%0d want=5", obs.size()); else n_pass++;
    for (int i = 0; i < 5 && i < obs.size(); i++) begin
      n_total++;
      if (obs[i] !== 8'(8'hD0 + i)) $display("FAIL full_order%0d got=%h want=%h", i, obs[i], 8'(8'hD0 + i));
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 8'(8'hE0 + i), 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    n_total++;
    if ({o_cnt_0, o_cnt_1} !== {4'd0, 4'd15}) $display("FAIL sat_count got=%h want=0f", {o_cnt_0, o_cnt_1});
    else n_pass++;
  endtask

  task automatic test_random();
    bit r, v0, v1, rd;
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      v0 = ($urandom_range(0, 99) < 60);
      v1 = ($urandom_range(0, 99) < 60);
      rd = ($urandom_range(0, 99) < 65);
      cycle(r, v0, 8'($urandom), v1, 8'($urandom), rd);
      n_total++;
      if (dut_vec() !== model_vec()) $display("FAIL random_cyc%0d got=%h want=%h", i, dut_vec(), model_vec());
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; i_vld_0 = 1'b0; i_vld_1 = 1'b0; i_data_0 = '0; i_data_1 = '0; i_rdy = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_full_pushpop();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
